fetch_stall_sequencer: RTL and testbench
========================================

Name: fetch_stall_sequencer

Overview:
- Consumer end of the pipeline stall handshake. Accepts StallOut/StallCountOut from the hazard control unit and owns the PC register and the IF/ID instruction register.
- Inserts STALL_OPCODE bubbles into ID, holds PC, counts down branch shadows and waits for jump redirects.
- Feeds its registered stall state back to the hazard unit's stall/StallCount inputs, closing the loop.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUBBLE_INSTR, {`STALL_OPCODE, 26'b0}, instruction word injected into ID during a stall (`STALL_OPCODE from config.v).

Ports:
CLK  input  1  pipeline clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-high reset.
StallReq  input  1  StallOut from hazard control; combinational, evaluated on current IDInstr/FetchInstr.
StallCountReq  input  32  StallCountOut from hazard control.
Redirect  input  1  one-cycle pulse: jump/jr target or taken-branch target resolved.
RedirectPC  input  32  target PC, valid with Redirect.
FetchInstr  input  32  instruction memory output at address PC.
PC  output  32  fetch address (registered).
IDInstr  output  32  IF/ID instruction register (registered); drives hazard instr; FetchInstr drives hazard nextInstr.
StallFb  output  1  registered stall feedback to hazard stall input.
StallCountFb  output  32  registered count feedback to hazard StallCount input.
Busy  output  1  high whenever state != RUN.

Behaviour:
- Reset (async, any state, including mid-count): PC=RESET_PC, IDInstr=32'h0, StallFb=0, StallCountFb=0, state=RUN, Busy=0. Takes effect immediately; first fetch is on the first edge after deassert.
- Control opcode: IDInstr[31:26] is 000100 (beq) or 000101 (bne), or 000010 (j) or 000011 (jal), or it is 000000 with funct 001000 (jr). Decoded from the registered IDInstr.
- States: RUN, COUNT, WAIT_REDIRECT.
- Priority each edge: RESET > Redirect > StallReq > normal advance.
- RUN, Redirect=1:
  - PC<=RedirectPC, IDInstr<=BUBBLE_INSTR, StallFb<=0, stay RUN.
  - Tolerated; no redirect is expected in RUN.
- RUN, StallReq=0: PC<=PC+4 (wraps mod 2^32), IDInstr<=FetchInstr.
- RUN, StallReq=1: PC held, IDInstr<=BUBBLE_INSTR. Then:
  - Control opcode and StallCountReq!=0: cnt<=StallCountReq, StallFb<=1, StallCountFb<=StallCountReq, go COUNT.
  - Control opcode and StallCountReq==0: StallFb<=1, StallCountFb<=0, go WAIT_REDIRECT.
  - Otherwise (data hazard): StallFb<=0, StallCountFb<=0, stay RUN. This is a single-cycle bubble; the hazard unit re-evaluates the next cycle.
- COUNT (branch shadow): PC held, IDInstr<=BUBBLE_INSTR each cycle.
  - Redirect=1: PC<=RedirectPC, StallFb<=0, StallCountFb<=0, go RUN (taken).
  - Else if cnt==1: StallFb<=0, StallCountFb<=0, go RUN. The PC is unchanged, so fall-through fetch resumes at branch+4.
  - Else: cnt<=cnt-1, StallCountFb<=cnt-1.
- WAIT_REDIRECT (jump): PC held, bubbles issued, StallFb=1, StallCountFb=0.
  - Stays in this state indefinitely until Redirect.
  - On Redirect: PC<=RedirectPC, StallFb<=0, go RUN.
- StallReq is ignored in COUNT and WAIT_REDIRECT: the sequencer is authoritative while Busy.
- Stall length: a branch with count N produces N+1 bubbles if not taken (1 entry cycle + N COUNT cycles). A redirect in COUNT ends the stall on that edge.
- StallCountReq is treated as unsigned 32-bit. No saturation is needed, since cnt only decrements to 1.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined: adds output StallCycles[31:0] and output RedirectCount[15:0].
  - StallCycles increments on every edge where a bubble is written to IDInstr.
  - RedirectCount increments on every accepted Redirect.
  - Both reset to 0 and wrap on overflow.
- Undefined: neither port nor the counter logic exists. Core behaviour is identical in both builds.

Test Plan:
1. Reset during COUNT (cnt=2) -> PC=0, IDInstr=0, StallFb=0, Busy=0 immediately; after release, PC sequence is 0,4,8.
2. Fetch add (no hazard), StallReq=0 for 3 cycles -> PC 0->4->8->12; IDInstr tracks FetchInstr one cycle later.
3. IDInstr=lw, StallReq=1 for 1 cycle (data hazard) -> one BUBBLE_INSTR, PC held one cycle, StallFb stays 0, state RUN.
4. IDInstr=beq at PC 0x10, StallReq=1, StallCountReq=2, no Redirect:
   - StallCountFb sequence is 2,1,0 with StallFb=1,1,0.
   - 3 bubbles issued; PC resumes advancing from 0x14.
5. Same beq, Redirect with RedirectPC=0x40 during the first COUNT cycle -> next PC=0x40, StallFb=0, state RUN, 2 bubbles total.
6. IDInstr=j, StallReq=1, StallCountReq=0 -> WAIT_REDIRECT for 5 cycles with StallFb=1; Redirect with RedirectPC=0x100 -> PC=0x100, Busy=0. With STALL_PERF_EN defined: StallCycles=6, RedirectCount=1.

Source files
------------

// File: rtl/fetch_stall_sequencer.sv
// Fetch-side stall sequencer: owns PC and the IF/ID register, and turns hazard-unit stall requests into bubbles.
// Build option STALL_PERF_EN adds the StallCycles/RedirectCount performance counters.
`ifndef STALL_OPCODE
`define STALL_OPCODE 6'b111111
`endif

module fetch_stall_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = {`STALL_OPCODE, 26'b0}
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        StallReq,
   input  logic [31:0] StallCountReq,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic [31:0] FetchInstr,
   output logic [31:0] PC,
   output logic [31:0] IDInstr,
   output logic        StallFb,
   output logic [31:0] StallCountFb,
   output logic        Busy
`ifdef STALL_PERF_EN
   ,
   output logic [31:0] StallCycles,
   output logic [15:0] RedirectCount
`endif
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_q, id_d;
   logic        fb_q, fb_d;
   logic [31:0] cfb_q, cfb_d;
   logic [31:0] cnt_q, cnt_d;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        is_ctrl;

   assign opcode = id_q[31:26];
   assign funct  = id_q[5:0];

   // beq, bne, j, jal, or R-type jr
   assign is_ctrl = (opcode == 6'b000100) || (opcode == 6'b000101) ||
                    (opcode == 6'b000010) || (opcode == 6'b000011) ||
                    ((opcode == 6'b000000) && (funct == 6'b001000));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      id_d    = id_q;
      fb_d    = fb_q;
      cfb_d   = cfb_q;
      cnt_d   = cnt_q;
      if (Redirect) begin
         pc_d    = RedirectPC;
         id_d    = BUBBLE_INSTR;
         fb_d    = 1'b0;
         cfb_d   = 32'h0;
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (StallReq) begin
                  id_d = BUBBLE_INSTR;
                  if (is_ctrl && (StallCountReq != 32'h0)) begin
                     cnt_d   = StallCountReq;
                     fb_d    = 1'b1;
                     cfb_d   = StallCountReq;
                     state_d = ST_COUNT;
                  end else if (is_ctrl) begin
                     fb_d    = 1'b1;
                     cfb_d   = 32'h0;
                     state_d = ST_WAIT;
                  end else begin
                     fb_d  = 1'b0;
                     cfb_d = 32'h0;
                  end
               end else begin
                  pc_d = pc_q + 32'd4;
                  id_d = FetchInstr;
               end
            end
            ST_COUNT: begin
               id_d = BUBBLE_INSTR;
               // PC was never advanced, so leaving here resumes fall-through fetch
               if (cnt_q <= 32'd1) begin
                  fb_d    = 1'b0;
                  cfb_d   = 32'h0;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - 32'd1;
                  cfb_d = cnt_q - 32'd1;
               end
            end
            ST_WAIT: begin
               id_d = BUBBLE_INSTR;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         id_q    <= 32'h0;
         fb_q    <= 1'b0;
         cfb_q   <= 32'h0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         id_q    <= id_d;
         fb_q    <= fb_d;
         cfb_q   <= cfb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PC           = pc_q;
   assign IDInstr      = id_q;
   assign StallFb      = fb_q;
   assign StallCountFb = cfb_q;
   assign Busy         = (state_q != ST_RUN);

`ifdef STALL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] redirect_count_q, redirect_count_d;

   // A bubble is written on every edge except a plain RUN advance
   always_comb begin
      stall_cycles_d   = stall_cycles_q;
      redirect_count_d = redirect_count_q;
      if (Redirect || StallReq || (state_q != ST_RUN)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (Redirect) begin
         redirect_count_d = redirect_count_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cycles_q   <= 32'h0;
         redirect_count_q <= 16'h0;
      end else begin
         stall_cycles_q   <= stall_cycles_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign StallCycles   = stall_cycles_q;
   assign RedirectCount = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_stall_sequencer.sv
// Scoreboard bench for fetch_stall_sequencer: stimulus pushes expected post-edge state, a negedge monitor compares.
// Reference model tracks "remaining shadow bubbles" and "waiting for jump target" rather than FSM states.
`timescale 1ns/1ps
module tb_fetch_stall_sequencer;

   localparam logic [31:0] BUBBLE = {6'b111111, 26'b0};
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        StallReq = 1'b0;
   logic [31:0] StallCountReq = 32'h0;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectPC = 32'h0;
   logic [31:0] FetchInstr = 32'h0;
   logic [31:0] PC;
   logic [31:0] IDInstr;
   logic        StallFb;
   logic [31:0] StallCountFb;
   logic        Busy;
`ifdef STALL_PERF_EN
   logic [31:0] StallCycles;
   logic [15:0] RedirectCount;
`endif

   fetch_stall_sequencer #(
      .RESET_PC     (RST_PC),
      .BUBBLE_INSTR (BUBBLE)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .StallReq      (StallReq),
      .StallCountReq (StallCountReq),
      .Redirect      (Redirect),
      .RedirectPC    (RedirectPC),
      .FetchInstr    (FetchInstr),
      .PC            (PC),
      .IDInstr       (IDInstr),
      .StallFb       (StallFb),
      .StallCountFb  (StallCountFb),
      .Busy          (Busy)
`ifdef STALL_PERF_EN
      ,
      .StallCycles   (StallCycles),
      .RedirectCount (RedirectCount)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [31:0] id;
      logic        fb;
      logic [31:0] cfb;
      logic        busy;
      logic [31:0] sc;
      logic [15:0] rc;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt = 0;
   int   n_compared = 0;
   int   n_mismatched = 0;

   // reference model state
   logic [31:0] m_pc, m_id, m_cfb, m_sc;
   logic [15:0] m_rc;
   logic        m_fb, m_jump;
   int          m_shadow;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   function automatic bit is_ctrl(input logic [31:0] ins);
      return (ins[31:26] inside {6'b000100, 6'b000101, 6'b000010, 6'b000011}) ||
             (ins[31:26] == 6'b000000 && ins[5:0] == 6'b001000);
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: return {6'b000100, r[25:0]};
         1: return {6'b000101, r[25:0]};
         2: return {6'b000010, r[25:0]};
         3: return {6'b000011, r[25:0]};
         4: return {6'b000000, r[25:6], 6'b001000};
         5: return {6'b100011, r[25:0]};
         default: return r;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_id = 32'h0; m_fb = 1'b0; m_cfb = 32'h0;
      m_shadow = 0; m_jump = 1'b0; m_sc = 32'h0; m_rc = 16'h0;
   endtask

   // Called at posedge+1: drive inputs, predict the state after the coming edge, then advance one cycle.
   task automatic step(input logic sr, input logic [31:0] scr, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] fi);
      exp_t e;
      bit   busy;
      StallReq = sr; StallCountReq = scr; Redirect = rd; RedirectPC = rpc; FetchInstr = fi;
      busy = (m_shadow > 0) || m_jump;
      if (rd || busy || sr) m_sc = m_sc + 32'd1;
      if (rd) begin
         m_rc = m_rc + 16'd1;
         m_pc = rpc; m_id = BUBBLE; m_fb = 1'b0; m_cfb = 32'h0;
         m_shadow = 0; m_jump = 1'b0;
      end else if (busy) begin
         m_id = BUBBLE;
         if (!m_jump) begin
            m_shadow = m_shadow - 1;
            m_cfb = 32'(m_shadow);
            m_fb = (m_shadow > 0);
         end
      end else if (sr) begin
         if (is_ctrl(m_id)) begin
            m_fb = 1'b1;
            m_cfb = scr;
            if (scr != 0) m_shadow = int'(scr);
            else m_jump = 1'b1;
         end else begin
            m_fb = 1'b0; m_cfb = 32'h0;
         end
         m_id = BUBBLE;
      end else begin
         m_pc = m_pc + 32'd4;
         m_id = fi;
      end
      e.tag = edge_cnt + 1; e.pc = m_pc; e.id = m_id; e.fb = m_fb; e.cfb = m_cfb;
      e.busy = (m_shadow > 0) || m_jump; e.sc = m_sc; e.rc = m_rc;
      sb.push_back(e);
      @(posedge CLK); #1;
   endtask

   task automatic idle(input logic [31:0] fi);
      step(1'b0, 32'h0, 1'b0, 32'h0, fi);
   endtask

   // Asserts reset between edges, checks the asynchronous effect, releases after one edge.
   task automatic reset_check();
      RESET = 1'b1;
      StallReq = 1'b0; Redirect = 1'b0;
      #1;
      chk("rst_pc", PC, RST_PC);
      chk("rst_id", IDInstr, 32'h0);
      chk("rst_fb", {31'h0, StallFb}, 32'h0);
      chk("rst_cfb", StallCountFb, 32'h0);
      chk("rst_busy", {31'h0, Busy}, 32'h0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_reset();
   endtask

   always @(negedge CLK) begin
      if (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
         exp_t e;
         e = sb.pop_front();
         chk("pc", PC, e.pc);
         chk("id_instr", IDInstr, e.id);
         chk("stall_fb", {31'h0, StallFb}, {31'h0, e.fb});
         chk("stall_count_fb", StallCountFb, e.cfb);
         chk("busy", {31'h0, Busy}, {31'h0, e.busy});
`ifdef STALL_PERF_EN
         chk("stall_cycles", StallCycles, e.sc);
         chk("redirect_count", {16'h0, RedirectCount}, {16'h0, e.rc});
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] beq_i, j_i, lw_i, add_i;
      beq_i = 32'h1022_0004;
      j_i   = 32'h0800_0040;
      lw_i  = 32'h8C22_0000;
      add_i = 32'h0022_1820;
      model_reset();
      @(posedge CLK); #1;
      reset_check();

      // plain fetch
      repeat (3) idle(add_i);
      // data hazard: single bubble, stays in RUN
      idle(lw_i);
      step(1'b1, 32'h0, 1'b0, 32'h0, add_i);
      idle(add_i);
      // branch shadow of 2, not taken
      idle(beq_i);
      step(1'b1, 32'd2, 1'b0, 32'h0, add_i);
      repeat (4) idle(add_i);
      // branch shadow of 2, taken in first COUNT cycle
      idle(beq_i);
      step(1'b1, 32'd2, 1'b0, 32'h0, add_i);
      step(1'b0, 32'h0, 1'b1, 32'h40, add_i);
      idle(add_i);
      // jump waits for its target; StallReq ignored while busy
      idle(j_i);
      step(1'b1, 32'h0, 1'b0, 32'h0, add_i);
      repeat (4) step(1'b1, 32'd3, 1'b0, 32'h0, add_i);
      step(1'b0, 32'h0, 1'b1, 32'h100, add_i);
      idle(add_i);
      // reset mid-count
      idle(beq_i);
      step(1'b1, 32'd3, 1'b0, 32'h0, add_i);
      idle(add_i);
      @(negedge CLK); #1;
      @(posedge CLK); #1;
      reset_check();
      repeat (3) idle(add_i);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic sr, rd;
         logic [31:0] rpc;
         sr  = ($urandom_range(0, 9) < 3);
         rd  = m_jump ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
         rpc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
         step(sr, 32'($urandom_range(0, 4)), rd, rpc, rand_instr());
      end

      @(negedge CLK); #1;
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
